// File: rtl/alpharetz_spi_pkg.sv
// Shared SPI parameters and the arbiter state encoding used by the SPI
// controller and the SPI arbiter.
package alpharetz_spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;
  localparam int P_ADDR_WIDTH   = 3;
  localparam int PERI_CNT       = 1 << P_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/alpharetz_rr_arbiter.sv
// Combinational round-robin pick: searches upward from the slot after the
// last grant, wrapping, and returns a one-hot winner and its index.
module alpharetz_rr_arbiter #(
  parameter int REQ_CNT = 4,
  parameter int IDX_W   = $clog2(REQ_CNT)
) (
  input  logic [REQ_CNT-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [REQ_CNT-1:0] winner,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    // i runs 1..REQ_CNT so the last grantee is considered last
    for (int i = 1; i <= REQ_CNT; i++) begin
      cand = IDX_W'((int'(last_idx) + i) % REQ_CNT);
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_idx      = cand;
        winner[cand] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/alpharetz_spi_arbiter.sv
// Round-robin arbiter sharing one SPI controller between REQ_CNT requesters;
// serialises whole transactions and reports completion, data and timeout.
module alpharetz_spi_arbiter #(
  parameter int REQ_CNT        = 4,
  parameter int SPI_DATA_WIDTH = alpharetz_spi_pkg::SPI_DATA_WIDTH,
  parameter int P_ADDR_WIDTH   = alpharetz_spi_pkg::P_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              sys_clk,
  input  logic                              sync_rst_n,
  input  logic                              sys_clk_en,
  input  logic [REQ_CNT-1:0]                req,
  input  logic [REQ_CNT*SPI_DATA_WIDTH-1:0] req_tx_data,
  input  logic [REQ_CNT*P_ADDR_WIDTH-1:0]   req_p_addr,
  output logic [REQ_CNT-1:0]                grant,
  output logic [REQ_CNT-1:0]                done,
  output logic                              err,
  output logic [SPI_DATA_WIDTH-1:0]         rx_data,
  output logic                              start_txn,
  output logic [SPI_DATA_WIDTH-1:0]         tx_data,
  output logic [P_ADDR_WIDTH-1:0]           p_addr,
  input  logic                              end_txn,
  input  logic [SPI_DATA_WIDTH-1:0]         ctrl_rx_data,
  output logic                              busy
);

  import alpharetz_spi_pkg::*;

  localparam int IDX_W = $clog2(REQ_CNT);
  localparam bit WD_ON = (TIMEOUT_CYCLES > 0);
  localparam int WD_W  = WD_ON ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_ON ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e state_q, state_nxt;

  logic [REQ_CNT-1:0]        grant_q, grant_nxt;
  logic [REQ_CNT-1:0]        done_q, done_nxt;
  logic                      err_q, err_nxt;
  logic [SPI_DATA_WIDTH-1:0] rx_q, rx_nxt;
  logic                      start_q, start_nxt;
  logic [SPI_DATA_WIDTH-1:0] tx_q, tx_nxt;
  logic [P_ADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic [WD_W-1:0]           wdog_q, wdog_nxt;
  logic [IDX_W-1:0]          last_q, last_nxt;

  logic [REQ_CNT-1:0]        win_onehot;
  logic [IDX_W-1:0]          win_idx;
  logic                      any_req;
  logic [SPI_DATA_WIDTH-1:0] tx_sel;
  logic [P_ADDR_WIDTH-1:0]   addr_sel;

  alpharetz_rr_arbiter #(
    .REQ_CNT (REQ_CNT),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req      (req),
    .last_idx (last_q),
    .winner   (win_onehot),
    .win_idx  (win_idx),
    .any      (any_req)
  );

  // Winner's slices, selected with constant indices from the one-hot vector
  always_comb begin
    tx_sel   = '0;
    addr_sel = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      if (win_onehot[i]) begin
        tx_sel   = req_tx_data[i*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
        addr_sel = req_p_addr[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
      end
    end
  end

  // Reset overrides the clock enable; otherwise state moves only on enabled edges
  always_ff @(posedge sys_clk) begin
    if (!sync_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rx_q    <= '0;
      start_q <= 1'b0;
      tx_q    <= '0;
      addr_q  <= '0;
      wdog_q  <= '0;
      last_q  <= IDX_W'(REQ_CNT - 1);
    end else if (sys_clk_en) begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      rx_q    <= rx_nxt;
      start_q <= start_nxt;
      tx_q    <= tx_nxt;
      addr_q  <= addr_nxt;
      wdog_q  <= wdog_nxt;
      last_q  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    done_nxt  = '0;
    err_nxt   = err_q;
    rx_nxt    = rx_q;
    start_nxt = 1'b0;
    tx_nxt    = tx_q;
    addr_nxt  = addr_q;
    wdog_nxt  = wdog_q;
    last_nxt  = last_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_nxt = START;
          grant_nxt = win_onehot;
          tx_nxt    = tx_sel;
          addr_nxt  = addr_sel;
          last_nxt  = win_idx;
          start_nxt = 1'b1;
        end
      end
      START: begin
        state_nxt = BUSY;
        wdog_nxt  = '0;
      end
      BUSY: begin
        // end_txn takes precedence over a watchdog expiry on the same cycle
        if (end_txn) begin
          rx_nxt    = ctrl_rx_data;
          err_nxt   = 1'b0;
          done_nxt  = grant_q;
          state_nxt = DONE;
        end else if (WD_ON && (wdog_q == WD_LAST)) begin
          rx_nxt    = '0;
          err_nxt   = 1'b1;
          done_nxt  = grant_q;
          state_nxt = DONE;
        end else if (WD_ON) begin
          wdog_nxt = wdog_q + 1'b1;
        end
      end
      DONE: begin
        grant_nxt = '0;
        wdog_nxt  = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rx_data   = rx_q;
  assign start_txn = start_q;
  assign tx_data   = tx_q;
  assign p_addr    = addr_q;
  assign busy      = (state_q != IDLE);

  a_grant_onehot0 : assert property (@(posedge sys_clk) disable iff (!sync_rst_n)
    $onehot0(grant_q));
  a_done_in_grant : assert property (@(posedge sys_clk) disable iff (!sync_rst_n)
    ((done_q & ~grant_q) == '0));

endmodule

// File: tb/tb_alpharetz_spi_arbiter.sv
// Bench for alpharetz_spi_arbiter: a default-timeout instance for arbitration
// and data paths, and a TIMEOUT_CYCLES=16 instance for watchdog corner cases.
module tb_alpharetz_spi_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int A = 3;

  logic           sys_clk = 1'b0;
  logic           sync_rst_n;
  logic           sys_clk_en;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_tx_data;
  logic [N*A-1:0] req_p_addr;
  logic           end_txn;
  logic [W-1:0]   ctrl_rx_data;

  logic [N-1:0] a_grant, a_done, t_grant, t_done;
  logic         a_err, a_start, a_busy, t_err, t_start, t_busy;
  logic [W-1:0] a_rx, a_tx, t_rx, t_tx;
  logic [A-1:0] a_addr, t_addr;

  alpharetz_spi_arbiter #(.REQ_CNT(N), .SPI_DATA_WIDTH(W), .P_ADDR_WIDTH(A),
                          .TIMEOUT_CYCLES(1024)) dut_a (
    .sys_clk(sys_clk), .sync_rst_n(sync_rst_n), .sys_clk_en(sys_clk_en),
    .req(req), .req_tx_data(req_tx_data), .req_p_addr(req_p_addr),
    .grant(a_grant), .done(a_done), .err(a_err), .rx_data(a_rx),
    .start_txn(a_start), .tx_data(a_tx), .p_addr(a_addr),
    .end_txn(end_txn), .ctrl_rx_data(ctrl_rx_data), .busy(a_busy));

  alpharetz_spi_arbiter #(.REQ_CNT(N), .SPI_DATA_WIDTH(W), .P_ADDR_WIDTH(A),
                          .TIMEOUT_CYCLES(16)) dut_t (
    .sys_clk(sys_clk), .sync_rst_n(sync_rst_n), .sys_clk_en(sys_clk_en),
    .req(req), .req_tx_data(req_tx_data), .req_p_addr(req_p_addr),
    .grant(t_grant), .done(t_done), .err(t_err), .rx_data(t_rx),
    .start_txn(t_start), .tx_data(t_tx), .p_addr(t_addr),
    .end_txn(end_txn), .ctrl_rx_data(ctrl_rx_data), .busy(t_busy));

  always #5 sys_clk = ~sys_clk;

  // sel picks which instance the shared check tasks observe
  logic         sel;
  logic [N-1:0] c_grant, c_done;
  logic         c_err, c_start, c_busy;
  logic [W-1:0] c_rx, c_tx;
  logic [A-1:0] c_addr;

  assign c_grant = sel ? t_grant : a_grant;
  assign c_done  = sel ? t_done  : a_done;
  assign c_err   = sel ? t_err   : a_err;
  assign c_start = sel ? t_start : a_start;
  assign c_busy  = sel ? t_busy  : a_busy;
  assign c_rx    = sel ? t_rx    : a_rx;
  assign c_tx    = sel ? t_tx    : a_tx;
  assign c_addr  = sel ? t_addr  : a_addr;

  typedef struct {
    logic [N-1:0] done;
    logic         err;
    logic [W-1:0] rx;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    logic [W-1:0] tx_base;
    logic [A-1:0] addr_base;
    int           delay;
    logic [W-1:0] rx;
    int           win;
    bit           drop;
  } vec_t;
  vec_t vecs[11];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    sync_rst_n   = 1'b0;
    sys_clk_en   = 1'b1;
    req          = '0;
    end_txn      = 1'b0;
    ctrl_rx_data = '0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("reset_a", {a_grant, a_done, a_err, a_rx, a_start, a_tx, a_addr, a_busy}, 32'd0);
    chk("reset_t", {t_grant, t_done, t_err, t_rx, t_start, t_tx, t_addr, t_busy}, 32'd0);
    sync_rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] exp_tx(input logic [W-1:0] base, input int w);
    return base ^ W'(w << 4);
  endfunction

  // Drive a request from IDLE and check the START cycle one edge later
  task automatic start_txn_chk(input logic [N-1:0] r, input logic [W-1:0] tx_base,
                               input logic [A-1:0] addr_base, input int win,
                               input logic [W-1:0] rx_exp, input logic err_exp);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      req_tx_data[i*W +: W] = exp_tx(tx_base, i);
      req_p_addr[i*A +: A]  = A'(addr_base + A'(i));
    end
    req = r;
    @(negedge sys_clk);
    chk("start_txn", {31'd0, c_start}, 32'd1);
    chk("grant", {28'd0, c_grant}, 32'd1 << win);
    chk("tx_data", {24'd0, c_tx}, {24'd0, exp_tx(tx_base, win)});
    chk("p_addr", {29'd0, c_addr}, {29'd0, A'(addr_base + A'(win))});
    chk("busy_start", {31'd0, c_busy}, 32'd1);
    e.done = N'(1 << win);
    e.err  = err_exp;
    e.rx   = rx_exp;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input int max, output int cyc);
    exp_t e;
    cyc = 0;
    while (c_done == '0 && cyc < max) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("done_seen", {31'd0, c_done != '0}, 32'd1);
    if (c_done != '0) begin
      chk("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("done", {28'd0, c_done}, {28'd0, e.done});
        chk("err", {31'd0, c_err}, {31'd0, e.err});
        chk("rx_data", {24'd0, c_rx}, {24'd0, e.rx});
        chk("done_in_grant", {28'd0, c_done & ~c_grant}, 32'd0);
      end
    end
  endtask

  task automatic finish_txn();
    @(negedge sys_clk);
    chk("done_pulse_end", {28'd0, c_done}, 32'd0);
    chk("grant_cleared", {28'd0, c_grant}, 32'd0);
    chk("idle_after_done", {31'd0, c_busy}, 32'd0);
  endtask

  task automatic end_pulse(input logic [W-1:0] rx);
    ctrl_rx_data = rx;
    end_txn      = 1'b1;
    @(negedge sys_clk);
    end_txn      = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc;
    int cnt;
    bit en_now;

    sel          = 1'b0;
    sync_rst_n   = 1'b0;
    sys_clk_en   = 1'b1;
    req          = '0;
    req_tx_data  = '0;
    req_p_addr   = '0;
    end_txn      = 1'b0;
    ctrl_rx_data = '0;

    //           rst  req      txb    ab    dly rx     win drop
    vecs[0]  = '{1'b1, 4'b0010, 8'hB5, 3'd2, 20, 8'h3C, 1, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 8'h10, 3'd0, 3,  8'h81, 0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 8'h20, 3'd1, 1,  8'h92, 1, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 8'h30, 3'd4, 5,  8'hA3, 2, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 8'h40, 3'd5, 2,  8'hB4, 3, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 8'h50, 3'd6, 4,  8'hC5, 0, 1'b0};
    vecs[6]  = '{1'b0, 4'b1000, 8'h60, 3'd7, 1,  8'hD6, 3, 1'b0};
    vecs[7]  = '{1'b0, 4'b0101, 8'h70, 3'd1, 2,  8'hE7, 0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0101, 8'h80, 3'd2, 3,  8'hF8, 2, 1'b0};
    vecs[9]  = '{1'b0, 4'b0110, 8'h90, 3'd3, 6,  8'h09, 1, 1'b1};
    vecs[10] = '{1'b0, 4'b0110, 8'hA0, 3'd4, 2,  8'h1A, 2, 1'b0};

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].rst) do_reset();
      sel = 1'b0;
      start_txn_chk(vecs[v].req, vecs[v].tx_base, vecs[v].addr_base, vecs[v].win,
                    vecs[v].rx, 1'b0);
      if (vecs[v].drop) req = '0;
      repeat (vecs[v].delay) @(negedge sys_clk);
      end_pulse(vecs[v].rx);
      wait_done(50, cyc);
      chk("end_to_done", cyc, 0);
      finish_txn();
    end

    // Timeout after 16 enabled BUSY cycles, then a stray end_txn in IDLE
    sel = 1'b1;
    do_reset();
    start_txn_chk(4'b0100, 8'h11, 3'd0, 2, 8'h00, 1'b1);
    wait_done(100, cyc);
    chk("timeout_latency", cyc, 17);
    req = '0;
    finish_txn();
    end_pulse(8'hFF);
    chk("late_end_done", {28'd0, t_done}, 32'd0);
    chk("late_end_busy", {31'd0, t_busy}, 32'd0);
    chk("late_end_rx", {24'd0, t_rx}, 32'd0);
    @(negedge sys_clk);
    chk("late_end_start", {31'd0, t_start}, 32'd0);

    // end_txn on the terminal watchdog cycle wins
    do_reset();
    start_txn_chk(4'b0001, 8'h22, 3'd5, 0, 8'h5A, 1'b0);
    repeat (16) @(negedge sys_clk);
    chk("no_early_timeout", {28'd0, t_done}, 32'd0);
    end_pulse(8'h5A);
    wait_done(5, cyc);
    chk("terminal_end_latency", cyc, 0);
    req = '0;
    finish_txn();

    // Clock enable gating: pulses hold, watchdog counts enabled edges only
    do_reset();
    start_txn_chk(4'b1000, 8'h33, 3'd1, 3, 8'h00, 1'b1);
    sys_clk_en = 1'b0;
    @(negedge sys_clk);
    chk("start_hold_en0", {31'd0, t_start}, 32'd1);
    sys_clk_en = 1'b1;
    @(negedge sys_clk);
    chk("start_one_cycle", {31'd0, t_start}, 32'd0);
    cnt = 0;
    for (int it = 0; it < 200 && t_done == '0; it++) begin
      en_now     = (it % 2) == 1;
      sys_clk_en = en_now;
      @(negedge sys_clk);
      if (en_now) cnt++;
    end
    chk("wd_enabled_cycles", cnt, 16);
    sys_clk_en = 1'b0;
    @(negedge sys_clk);
    chk("done_hold_en0", {28'd0, t_done}, 32'h8);
    sys_clk_en = 1'b1;
    wait_done(1, cyc);
    req = '0;
    finish_txn();

    // Reset mid-BUSY with the clock enable low
    start_txn_chk(4'b0010, 8'h44, 3'd6, 1, 8'h00, 1'b0);
    void'(sbq.pop_back());
    repeat (3) @(negedge sys_clk);
    sys_clk_en = 1'b0;
    sync_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("rst_mid_busy_t", {t_grant, t_done, t_err, t_rx, t_start, t_tx, t_addr, t_busy}, 32'd0);
    chk("rst_mid_busy_a", {a_grant, a_done, a_err, a_rx, a_start, a_tx, a_addr, a_busy}, 32'd0);
    sync_rst_n = 1'b1;
    sys_clk_en = 1'b1;
    req        = '0;
    @(negedge sys_clk);
    chk("idle_after_rst", {31'd0, t_busy}, 32'd0);
    start_txn_chk(4'b1111, 8'h55, 3'd2, 0, 8'h77, 1'b0);
    repeat (2) @(negedge sys_clk);
    end_pulse(8'h77);
    wait_done(5, cyc);
    req = '0;
    finish_txn();

    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
